// File: rtl/division_16bits_seq_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding, default sizing
// and saturation constants. Signed operation is enabled by defining DIV_SIGNED_EN.
package division_16bits_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH     = 16;
  localparam int DEF_FRAC_BITS = 0;

  // Saturation values for a w-bit result, returned wide and truncated by the caller.
  function automatic logic [63:0] sat_umax(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_smax(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_smin(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/division_16bits_seq_step.sv
// One combinational restoring-division iteration: shift in the next dividend bit,
// trial-subtract the divisor, keep the difference only when it does not go negative.
module division_16bits_seq_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {rem_i, bit_i};
  assign diff    = shifted - {1'b0, divisor_i};

  // Trial subtract with restore; a kept remainder is always below the divisor so it fits WIDTH bits.
  always_comb begin
    rem_o   = shifted[WIDTH-1:0];
    q_bit_o = 1'b0;
    if (shifted >= {1'b0, divisor_i}) begin
      rem_o   = diff[WIDTH-1:0];
      q_bit_o = 1'b1;
    end else begin
      rem_o   = shifted[WIDTH-1:0];
      q_bit_o = 1'b0;
    end
  end

endmodule

// File: rtl/division_16bits_seq.sv
// Sequential radix-2 restoring divider with start/done handshake and Q-format pre-scaling.
// Define DIV_SIGNED_EN for two's-complement operands (magnitude divide plus sign fixup).
module division_16bits_seq
  import division_16bits_seq_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int FRAC_BITS = DEF_FRAC_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic             ovf
);

  localparam int N     = WIDTH + FRAC_BITS;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N-1:0]       shift_q, shift_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   div_q, div_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   r_q, r_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;
  logic               ovf_q, ovf_d;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [N-1:0]       dividend;
  logic [WIDTH-1:0]   step_rem;
  logic               step_qbit;

`ifdef DIV_SIGNED_EN
  localparam logic [WIDTH-1:0] Q_SMAX = WIDTH'(sat_smax(WIDTH));
  localparam logic [WIDTH-1:0] Q_SMIN = WIDTH'(sat_smin(WIDTH));

  logic             a_neg_q, a_neg_d;
  logic             b_neg_q, b_neg_d;
  logic             q_neg;
  logic [WIDTH-1:0] q_lim;

  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b[WIDTH-1] ? -b : b;
  assign q_neg = a_neg_q ^ b_neg_q;
  // The most-negative pattern doubles as the largest negative magnitude.
  assign q_lim = q_neg ? Q_SMIN : Q_SMAX;
`else
  localparam logic [WIDTH-1:0] Q_UMAX = WIDTH'(sat_umax(WIDTH));

  logic hi_nz;

  assign a_mag = a;
  assign b_mag = b;
  assign hi_nz = (shift_q >> WIDTH) != {N{1'b0}};
`endif

  assign dividend = N'(a_mag) << FRAC_BITS;

  division_16bits_seq_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .bit_i     (shift_q[N-1]),
    .divisor_i (div_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_qbit)
  );

  // Next-state, datapath and result fixup; quotient bits shift into the dividend register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    rem_d   = rem_q;
    div_d   = div_q;
    a_d     = a_q;
    q_d     = q_q;
    r_d     = r_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
`ifdef DIV_SIGNED_EN
    a_neg_d = a_neg_q;
    b_neg_d = b_neg_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          div_d   = b_mag;
          rem_d   = {WIDTH{1'b0}};
          shift_d = dividend;
          busy_d  = 1'b1;
          cnt_d   = CNT_W'(N - 1);
`ifdef DIV_SIGNED_EN
          a_neg_d = a[WIDTH-1];
          b_neg_d = b[WIDTH-1];
`endif
          if (b == {WIDTH{1'b0}}) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_CALC;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        rem_d   = step_rem;
        shift_d = {shift_q[N-2:0], step_qbit};
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_CALC;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
        if (div_q == {WIDTH{1'b0}}) begin
          dbz_d = 1'b1;
          ovf_d = 1'b0;
          r_d   = a_q;
`ifdef DIV_SIGNED_EN
          q_d   = a_neg_q ? Q_SMIN : Q_SMAX;
`else
          q_d   = Q_UMAX;
`endif
        end else begin
          dbz_d = 1'b0;
`ifdef DIV_SIGNED_EN
          ovf_d = shift_q > N'(q_lim);
          if (ovf_d) begin
            q_d = q_lim;
          end else if (q_neg) begin
            q_d = -shift_q[WIDTH-1:0];
          end else begin
            q_d = shift_q[WIDTH-1:0];
          end
          r_d   = a_neg_q ? -rem_q : rem_q;
`else
          ovf_d = hi_nz;
          q_d   = hi_nz ? Q_UMAX : shift_q[WIDTH-1:0];
          r_d   = rem_q;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous abort-on-reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      shift_q <= {N{1'b0}};
      rem_q   <= {WIDTH{1'b0}};
      div_q   <= {WIDTH{1'b0}};
      a_q     <= {WIDTH{1'b0}};
      q_q     <= {WIDTH{1'b0}};
      r_q     <= {WIDTH{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      a_q     <= a_d;
      q_q     <= q_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
`ifdef DIV_SIGNED_EN
      a_neg_q <= a_neg_d;
      b_neg_q <= b_neg_d;
`endif
    end
  end

  assign q    = q_q;
  assign r    = r_q;
  assign busy = busy_q;
  assign done = done_q;
  assign dbz  = dbz_q;
  assign ovf  = ovf_q;

endmodule
